// File: rtl/irq_seq.sv
// irq_seq: interrupt/reset sequencer beside the 65C02 microcode controller.
// Define WAI_STP_EN to build the WAI/STP halt states; otherwise halt is tied low.
module irq_seq #(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned RESET_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       irq_n,
   input  logic       nmi_n,
   input  logic       sync,
   input  logic       I,
   input  logic       brk,
   input  logic       wai,
   input  logic       stp,
   input  logic       vec_ack,
   output logic       take_int,
   output logic [7:0] vec_lo,
   output logic       b_flag,
   output logic       halt,
   output logic       core_reset
);

   localparam logic [2:0] ST_RST  = 3'd0;
   localparam logic [2:0] ST_RUN  = 3'd1;
   localparam logic [2:0] ST_INT  = 3'd2;
`ifdef WAI_STP_EN
   localparam logic [2:0] ST_WAIT = 3'd3;
   localparam logic [2:0] ST_STOP = 3'd4;
`endif

   localparam logic [1:0] SRC_RESET = 2'd0;
   localparam logic [1:0] SRC_NMI   = 2'd1;
   localparam logic [1:0] SRC_IRQ   = 2'd2;
   localparam logic [1:0] SRC_BRK   = 2'd3;

   logic [SYNC_STAGES-1:0] irq_sr;
   logic [SYNC_STAGES-1:0] nmi_sr;
   logic                   irq_s;
   logic                   nmi_s;
   logic                   nmi_d;
   logic                   nmi_pend;
   logic                   irq_act;
   logic [2:0]             state;
   logic [1:0]             src;
   logic [3:0]             rst_cnt;

   assign irq_s = irq_sr[SYNC_STAGES-1];
   assign nmi_s = nmi_sr[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_sr <= '1;
         nmi_sr <= '1;
         nmi_d  <= 1'b1;
      end else begin
         irq_sr <= {irq_sr[SYNC_STAGES-2:0], irq_n};
         nmi_sr <= {nmi_sr[SYNC_STAGES-2:0], nmi_n};
         nmi_d  <= nmi_s;
      end
   end

   // A fresh edge outranks the acknowledge so a back-to-back NMI is never lost.
   always_ff @(posedge clk) begin
      if (reset)
         nmi_pend <= 1'b0;
      else if (nmi_d && !nmi_s)
         nmi_pend <= 1'b1;
      else if (vec_ack && src == SRC_NMI)
         nmi_pend <= 1'b0;
   end

   assign irq_act  = ~irq_s & ~I;
   assign take_int = (state == ST_RUN) & sync & (nmi_pend | irq_act);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_RST;
         src     <= SRC_RESET;
         rst_cnt <= 4'(RESET_CYCLES);
      end else begin
         case (state)
            ST_RST: begin
               rst_cnt <= rst_cnt - 4'd1;
               // Leaving on the count of one makes core_reset last exactly RESET_CYCLES.
               if (rst_cnt <= 4'd1) begin
                  state <= ST_INT;
                  src   <= SRC_RESET;
               end
            end
            ST_RUN: begin
               if (take_int) begin
                  state <= ST_INT;
                  src   <= nmi_pend ? SRC_NMI : SRC_IRQ;
               end else if (brk) begin
                  state <= ST_INT;
                  src   <= SRC_BRK;
               end
`ifdef WAI_STP_EN
               else if (wai)
                  state <= ST_WAIT;
               else if (stp)
                  state <= ST_STOP;
`endif
            end
            ST_INT: begin
               if (vec_ack)
                  state <= ST_RUN;
            end
`ifdef WAI_STP_EN
            ST_WAIT: begin
               if (nmi_pend || !irq_s)
                  state <= ST_RUN;
            end
            ST_STOP: state <= ST_STOP;
`endif
            default: state <= ST_RST;
         endcase
      end
   end

   always_comb begin
      vec_lo = 8'hFE;
      if (state == ST_RST) begin
         vec_lo = 8'hFC;
      end else if (state == ST_INT) begin
         case (src)
            SRC_RESET: vec_lo = 8'hFC;
            SRC_NMI:   vec_lo = 8'hFA;
            default:   vec_lo = 8'hFE;
         endcase
      end
   end

   assign b_flag     = (state == ST_INT) & (src == SRC_BRK);
   assign core_reset = (state == ST_RST);

`ifdef WAI_STP_EN
   assign halt = (state == ST_WAIT) | (state == ST_STOP);
`else
   logic unused_ok;
   assign unused_ok = wai | stp;
   assign halt      = 1'b0;
`endif

endmodule

// File: tb/tb_irq_seq.sv
// Self-checking bench for irq_seq: per-cycle behavioural model plus directed literal checks.
module tb_irq_seq;
   localparam int SYNC = 2;
   localparam int RCYC = 4;
`ifdef WAI_STP_EN
   localparam bit WAIS = 1'b1;
`else
   localparam bit WAIS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       irq_n = 1'b1;
   logic       nmi_n = 1'b1;
   logic       sync = 1'b0;
   logic       I = 1'b0;
   logic       brk = 1'b0;
   logic       wai = 1'b0;
   logic       stp = 1'b0;
   logic       vec_ack = 1'b0;
   logic       take_int;
   logic [7:0] vec_lo;
   logic       b_flag;
   logic       halt;
   logic       core_reset;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   irq_seq #(.SYNC_STAGES(SYNC), .RESET_CYCLES(RCYC)) dut (
      .clk(clk), .reset(reset), .irq_n(irq_n), .nmi_n(nmi_n), .sync(sync),
      .I(I), .brk(brk), .wai(wai), .stp(stp), .vec_ack(vec_ack),
      .take_int(take_int), .vec_lo(vec_lo), .b_flag(b_flag), .halt(halt),
      .core_reset(core_reset)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_RST, M_RUN, M_INT, M_WAIT, M_STOP} mmode_t;
   typedef enum {S_RESET, S_NMI, S_IRQ, S_BRK} msrc_t;

   mmode_t mm = M_RST;
   msrc_t  ms = S_RESET;
   int     rst_left = RCYC;
   bit     pend = 1'b0;
   int     ecount = 0;
   bit     irq_log [0:4095];
   bit     nmi_log [0:4095];
   bit     rst_log [0:4095];

   // Synchronised view of a pin: the sample taken 'age' edges before the last one,
   // or 1 if any reset edge falls inside that window.
   function automatic bit m_s(input bit is_nmi, input int age);
      int last = ecount - 1;
      int idx  = last - age;
      if (idx < 0) return 1'b1;
      for (int j = idx; j <= last; j++)
         if (rst_log[j]) return 1'b1;
      return is_nmi ? nmi_log[idx] : irq_log[idx];
   endfunction

   function automatic bit m_take();
      return (mm == M_RUN) && sync && (pend || (!m_s(1'b0, SYNC - 1) && !I));
   endfunction

   function automatic logic [7:0] m_vec();
      if (mm == M_RST) return 8'hFC;
      if (mm != M_INT) return 8'hFE;
      case (ms)
         S_RESET: return 8'hFC;
         S_NMI:   return 8'hFA;
         default: return 8'hFE;
      endcase
   endfunction

   always @(posedge clk) begin
      irq_log[ecount] <= irq_n;
      nmi_log[ecount] <= nmi_n;
      rst_log[ecount] <= reset;
      ecount <= ecount + 1;
      if (reset) begin
         mm       <= M_RST;
         ms       <= S_RESET;
         rst_left <= RCYC;
         pend     <= 1'b0;
      end else begin
         if (m_s(1'b1, SYNC) && !m_s(1'b1, SYNC - 1))
            pend <= 1'b1;
         else if (vec_ack && ms == S_NMI)
            pend <= 1'b0;
         case (mm)
            M_RST: begin
               rst_left <= rst_left - 1;
               if (rst_left == 1) begin
                  mm <= M_INT;
                  ms <= S_RESET;
               end
            end
            M_RUN: begin
               if (m_take()) begin
                  mm <= M_INT;
                  ms <= pend ? S_NMI : S_IRQ;
               end else if (brk) begin
                  mm <= M_INT;
                  ms <= S_BRK;
               end else if (WAIS && wai) begin
                  mm <= M_WAIT;
               end else if (WAIS && stp) begin
                  mm <= M_STOP;
               end
            end
            M_INT:  if (vec_ack) mm <= M_RUN;
            M_WAIT: if (pend || !m_s(1'b0, SYNC - 1)) mm <= M_RUN;
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk1("m_take_int", take_int, m_take());
         chk8("m_vec_lo", vec_lo, m_vec());
         chk1("m_b_flag", b_flag, (mm == M_INT) && (ms == S_BRK));
         chk1("m_halt", halt, (mm == M_WAIT) || (mm == M_STOP));
         chk1("m_core_reset", core_reset, mm == M_RST);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      step(1);
      chk_en = 1'b1;
      step(2);
      @(negedge clk);
      chk1("rst_core_reset", core_reset, 1'b1);
      chk8("rst_vec_lo", vec_lo, 8'hFC);
      chk1("rst_halt", halt, 1'b0);
      chk1("rst_take_int", take_int, 1'b0);
      chk1("rst_b_flag", b_flag, 1'b0);
      step(1);
      reset = 1'b0;
      for (int i = 0; i < RCYC; i++) begin
         @(negedge clk);
         chk1("stretch_core_reset", core_reset, 1'b1);
         step(1);
      end
      @(negedge clk);
      chk1("stretch_released", core_reset, 1'b0);
      chk8("reset_vector", vec_lo, 8'hFC);
      step(1); vec_ack = 1'b1;
      step(1); vec_ack = 1'b0;
      @(negedge clk);
      chk8("run_vec_lo", vec_lo, 8'hFE);

      // IRQ enabled, then masked
      step(1); I = 1'b0; irq_n = 1'b0;
      step(3); sync = 1'b1;
      @(negedge clk);
      chk1("irq_take", take_int, 1'b1);
      step(1); sync = 1'b0;
      @(negedge clk);
      chk8("irq_vec", vec_lo, 8'hFE);
      chk1("irq_b_flag", b_flag, 1'b0);
      step(1); vec_ack = 1'b1; irq_n = 1'b1;
      step(1); vec_ack = 1'b0;
      step(3); I = 1'b1; irq_n = 1'b0;
      step(3); sync = 1'b1;
      @(negedge clk);
      chk1("irq_masked", take_int, 1'b0);
      step(1); sync = 1'b0; irq_n = 1'b1;
      step(3); I = 1'b0;

      // NMI with IRQ also pending, second edge coinciding with the ack
      irq_n = 1'b0; nmi_n = 1'b0;
      step(4); sync = 1'b1;
      @(negedge clk);
      chk1("nmi_take", take_int, 1'b1);
      step(1); sync = 1'b0;
      @(negedge clk);
      chk8("nmi_vec", vec_lo, 8'hFA);
      step(1); nmi_n = 1'b1;
      step(3); nmi_n = 1'b0;
      step(2); vec_ack = 1'b1;
      step(1); vec_ack = 1'b0; sync = 1'b1;
      @(negedge clk);
      chk1("nmi_repend_take", take_int, 1'b1);
      step(1); sync = 1'b0;
      @(negedge clk);
      chk8("nmi_repend_vec", vec_lo, 8'hFA);
      step(1); vec_ack = 1'b1;
      step(1); vec_ack = 1'b0; sync = 1'b1;
      @(negedge clk);
      chk1("irq_after_nmi_take", take_int, 1'b1);
      step(1); sync = 1'b0;
      @(negedge clk);
      chk8("irq_after_nmi_vec", vec_lo, 8'hFE);
      step(1); vec_ack = 1'b1; irq_n = 1'b1;
      step(1); vec_ack = 1'b0; nmi_n = 1'b1;
      step(3);

      // BRK, with an NMI arriving inside the BRK entry
      brk = 1'b1;
      step(1); brk = 1'b0;
      @(negedge clk);
      chk8("brk_vec", vec_lo, 8'hFE);
      chk1("brk_b_flag", b_flag, 1'b1);
      step(1); nmi_n = 1'b0;
      step(4);
      @(negedge clk);
      chk8("brk_no_hijack_vec", vec_lo, 8'hFE);
      chk1("brk_no_hijack_b", b_flag, 1'b1);
      step(1); vec_ack = 1'b1;
      step(1); vec_ack = 1'b0; sync = 1'b1;
      @(negedge clk);
      chk1("nmi_after_brk_take", take_int, 1'b1);
      step(1); sync = 1'b0;
      @(negedge clk);
      chk8("nmi_after_brk_vec", vec_lo, 8'hFA);
      step(1); vec_ack = 1'b1; nmi_n = 1'b1;
      step(1); vec_ack = 1'b0;
      step(3);

      // WAI with I=1, woken by IRQ level
      I = 1'b1; wai = 1'b1;
      step(1); wai = 1'b0; irq_n = 1'b0;
`ifdef WAI_STP_EN
      @(negedge clk); chk1("wai_halt", halt, 1'b1);
      step(1);
      @(negedge clk); chk1("wai_halt_sync1", halt, 1'b1);
      step(1);
      @(negedge clk); chk1("wai_halt_sync2", halt, 1'b1);
      step(1);
      @(negedge clk); chk1("wai_woken", halt, 1'b0);
`else
      @(negedge clk); chk1("wai_ignored", halt, 1'b0);
      step(3);
`endif
      sync = 1'b1;
      @(negedge clk);
      chk1("wai_resume_no_take", take_int, 1'b0);
      step(1); sync = 1'b0; irq_n = 1'b1;
      step(3); I = 1'b0;

      // STP holds through NMI edges until reset
      stp = 1'b1;
      step(1); stp = 1'b0; nmi_n = 1'b0;
      step(4); nmi_n = 1'b1;
      step(3); nmi_n = 1'b0;
      step(4); sync = 1'b1;
      @(negedge clk);
`ifdef WAI_STP_EN
      chk1("stp_halt", halt, 1'b1);
      chk1("stp_no_take", take_int, 1'b0);
`else
      chk1("stp_ignored_halt", halt, 1'b0);
      chk1("stp_ignored_take", take_int, 1'b1);
`endif
      step(1); sync = 1'b0; nmi_n = 1'b1; reset = 1'b1;
      step(2);
      @(negedge clk);
      chk1("stp_reset_core_reset", core_reset, 1'b1);
      chk1("stp_reset_halt", halt, 1'b0);
      step(1); reset = 1'b0;
      step(RCYC);
      @(negedge clk);
      chk1("rst2_released", core_reset, 1'b0);
      step(1); vec_ack = 1'b1;
      step(1); vec_ack = 1'b0;

      // Reset while inside an NMI entry with another NMI pending
      nmi_n = 1'b0;
      step(4); sync = 1'b1;
      @(negedge clk);
      chk1("nmi2_take", take_int, 1'b1);
      step(1); sync = 1'b0; nmi_n = 1'b1;
      @(negedge clk);
      chk8("nmi2_vec", vec_lo, 8'hFA);
      step(3); nmi_n = 1'b0;
      step(3); nmi_n = 1'b1; reset = 1'b1;
      step(1);
      @(negedge clk);
      chk1("int_reset_core_reset", core_reset, 1'b1);
      chk1("int_reset_take", take_int, 1'b0);
      chk8("int_reset_vec", vec_lo, 8'hFC);
      step(1); reset = 1'b0;
      step(RCYC);
      step(1); vec_ack = 1'b1;
      step(1); vec_ack = 1'b0; sync = 1'b1;
      @(negedge clk);
      chk1("pend_cleared_by_reset", take_int, 1'b0);
      step(1); sync = 1'b0;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/irq_seq.md
Name: irq_seq

Overview:
Interrupt/reset sequencer for the 65C02 microcoded core. Sits beside the microcode controller. Synchronises external IRQ/NMI, latches the NMI edge, and decides at each instruction boundary (sync) whether the sequencer decodes the next opcode or enters the interrupt microcode. Supplies the vector low byte and B flag for the stack push, stretches core reset, and implements WAI/STP halting.

Parameters:
SYNC_STAGES, 2, flip-flop stages on irq_n/nmi_n (min 2)
RESET_CYCLES, 4, cycles core_reset stays high after reset deasserts (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
irq_n  in  1  async level IRQ, active low
nmi_n  in  1  async NMI, falling-edge triggered
sync  in  1  sequencer is at opcode-decode cycle
I  in  1  processor interrupt-disable flag
brk  in  1  one-cycle pulse: BRK opcode decoded
wai  in  1  one-cycle pulse: WAI opcode executed
stp  in  1  one-cycle pulse: STP opcode executed
vec_ack  in  1  sequencer fetched vector low byte this cycle
take_int  out  1  divert sequencer to interrupt entry instead of decoding DB
vec_lo  out  8  vector address low byte (page FF)
b_flag  out  1  B bit value for status push
halt  out  1  freeze core clock-enable
core_reset  out  1  stretched reset to core

Behaviour:
- Reset decided: reset reset, synchronous, active-high; clock clk.
- Synchronisers: irq_n/nmi_n each through SYNC_STAGES flops (reset to 1) -> irq_s, nmi_s. One extra flop nmi_d for edge detection.
- nmi_pend set when nmi_d=1 & nmi_s=0. Cleared on vec_ack while src=NMI. If set and clear occur together, set wins.
- irq_act = ~irq_s & ~I (combinational).
- States: RST, RUN, INT, WAIT, STOP. Register src in {RESET, NMI, IRQ, BRK}.
- RST: core_reset=1; 4-bit counter loads RESET_CYCLES on reset, decrements while reset=0; at 0 -> INT with src=RESET, core_reset drops the same edge.
- RUN: take_int = sync & (nmi_pend | irq_act) (combinational, same cycle). On take_int -> INT, src=NMI if nmi_pend, else IRQ (NMI priority). Else brk -> INT src=BRK; wai -> WAIT; stp -> STOP. brk/wai/stp ignored in any cycle where take_int=1.
- INT: vec_lo/b_flag held from src, which is latched at entry. No hijack: an NMI arriving during INT stays pending and is served at the next sync. vec_ack -> RUN.
- WAIT: halt=1. Wake condition nmi_pend | ~irq_s, regardless of I. Registered to RUN; halt low the cycle after the wake condition is sampled. Interrupt then taken at next sync if enabled. With I=1 and IRQ, execution simply resumes.
- STOP: halt=1 until reset. NMI/IRQ ignored, but nmi_pend still latches edges.
- vec_lo: RESET=FC, NMI=FA, IRQ/BRK=FE. Outside INT, vec_lo=FE.
- b_flag=1 only in INT with src=BRK, else 0.
- take_int=0 outside RUN.
- Reset values: state RST, core_reset=1, halt=0, take_int=0, vec_lo=FC, b_flag=0, nmi_pend=0, src=RESET.
- Reset mid-operation (any state, including INT/WAIT/STOP) aborts immediately to RST and clears nmi_pend.

Optional Feature:
WAI_STP_EN. Defined: WAIT/STOP states and halt behave as above. Undefined: wai/stp inputs ignored, WAIT/STOP states not built, halt tied 0.

Test Plan:
- Reset 3 cycles, RESET_CYCLES=4 -> core_reset high until 4th cycle after release; vec_lo=FC until vec_ack, then RUN.
- irq_n low, I=0, sync pulse after SYNC_STAGES+ cycles -> take_int=1 that cycle, vec_lo=FE, b_flag=0. Same with I=1 -> take_int stays 0.
- nmi_n falling edge while irq_n low, I=0 -> NMI served first (vec_lo=FA); after vec_ack, next sync takes IRQ (FE). Second NMI edge in ack cycle -> nmi_pend stays 1.
- brk pulse in RUN -> INT with vec_lo=FE, b_flag=1. NMI during INT -> vector stays FE; NMI taken at next sync.
- wai with I=1, then irq_n low -> halt drops one cycle after synced IRQ, no take_int. stp -> halt stays 1 through NMI edges until reset.
- Reset asserted while in INT (src=NMI) -> state RST, nmi_pend=0, take_int=0.
